// File: rtl/rf_param_bypass.sv
// Parametrised 2-read/1-write register file with registered reads,
// write->read bypass, optional zero register and busy scoreboard.
module rf_param_bypass #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              re0,
    input  logic              re1,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic              p0_busy,
    output logic              p1_busy,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] dst,
    input  logic              we,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              rsv_en,
    input  logic              hlt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic ZR = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] A0 = '0;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] p0_q, p0_d, p1_q, p1_d;
    logic              p0b_q, p0b_d, p1b_q, p1b_d;
    logic              hlt_q;

    logic wr_ok, rsv_ok, hit0, hit1;

    always_comb begin
        wr_ok  = we && !(ZR && dst_addr == A0);
        rsv_ok = rsv_en && !(ZR && rsv_addr == A0);
        hit0   = we && dst_addr == p0_addr && !(ZR && p0_addr == A0);
        hit1   = we && dst_addr == p1_addr && !(ZR && p1_addr == A0);

        // Reserve is applied after the write clear so a collision leaves busy set.
        busy_d = busy_q;
        if (wr_ok)
            busy_d[dst_addr] = 1'b0;
        if (rsv_ok)
            busy_d[rsv_addr] = 1'b1;

        p0_d  = p0_q;
        p0b_d = p0b_q;
        if (re0) begin
            p0_d  = hit0 ? dst : mem_q[p0_addr];
            p0b_d = busy_q[p0_addr] && !hit0;
        end

        p1_d  = p1_q;
        p1b_d = p1b_q;
        if (re1) begin
            p1_d  = hit1 ? dst : mem_q[p1_addr];
            p1b_d = busy_q[p1_addr] && !hit1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            busy_q <= '0;
            p0_q   <= '0;
            p1_q   <= '0;
            p0b_q  <= 1'b0;
            p1b_q  <= 1'b0;
            hlt_q  <= 1'b0;
        end else begin
            if (wr_ok)
                mem_q[dst_addr] <= dst;
            busy_q <= busy_d;
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            p0b_q  <= p0b_d;
            p1b_q  <= p1b_d;
            hlt_q  <= hlt;
        end
    end

    assign p0      = p0_q;
    assign p1      = p1_q;
    assign p0_busy = p0b_q;
    assign p1_busy = p1b_q;

`ifndef SYNTHESIS
    // Runs before the NBA region, so it shows the pre-edge contents.
    always @(posedge clk) begin
        if (!rst && hlt && !hlt_q) begin
            for (int i = (ZR ? 1 : 0); i < DEPTH; i++)
                $display("R%1h = %h", i, mem_q[i]);
        end
    end
`endif

endmodule

// File: tb/tb_rf_param_bypass.sv
// Directed-vector scoreboard bench for rf_param_bypass.
module tb_rf_param_bypass;

    logic        clk = 1'b0;
    logic        rst, re0, re1, we, rsv_en, hlt;
    logic [3:0]  p0_addr, p1_addr, dst_addr, rsv_addr;
    logic [15:0] dst, p0, p1;
    logic        p0_busy, p1_busy;

    rf_param_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .re0(re0), .re1(re1),
        .p0(p0), .p1(p1),
        .p0_busy(p0_busy), .p1_busy(p1_busy),
        .dst_addr(dst_addr), .dst(dst), .we(we),
        .rsv_addr(rsv_addr), .rsv_en(rsv_en),
        .hlt(hlt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        bit          port;
        logic [15:0] d;
        logic        b;
        string       name;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: outputs are valid at the negedge after the tagged edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= edge_cnt) begin
            exp_t e;
            logic [15:0] ad;
            logic        ab;
            e = q.pop_front();
            ad = e.port ? p1 : p0;
            ab = e.port ? p1_busy : p0_busy;
            n_vec++;
            if (e.tag != edge_cnt || ad !== e.d) begin
                n_bad++;
                $display("FAIL %s p%0d data: got %h want %h (tag %0d at %0d)",
                         e.name, e.port, ad, e.d, e.tag, edge_cnt);
            end
            n_vec++;
            if (ab !== e.b) begin
                n_bad++;
                $display("FAIL %s p%0d busy: got %b want %b",
                         e.name, e.port, ab, e.b);
            end
        end
    end

    task automatic exp_p(input bit port, input logic [15:0] d,
                         input logic b, input string name);
        exp_t e;
        e.tag  = edge_cnt + 1;
        e.port = port;
        e.d    = d;
        e.b    = b;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        rst = 0; re0 = 0; re1 = 0; we = 0; rsv_en = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        hlt = 0; dst = 0; dst_addr = 0; rsv_addr = 0;
        p0_addr = 0; p1_addr = 0;
        idle();

        // Reset with conflicting write/reserve/read activity
        for (int c = 0; c < 2; c++) begin
            rst = 1; we = 1; dst = 16'hFFFF; dst_addr = 3;
            rsv_en = 1; rsv_addr = 4;
            re0 = 1; p0_addr = 3; re1 = 1; p1_addr = 4;
            exp_p(0, 16'h0000, 0, "reset");
            exp_p(1, 16'h0000, 0, "reset");
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            re0 = 1; p0_addr = 4'(i);
            re1 = 1; p1_addr = 4'(i + 8);
            exp_p(0, 16'h0000, 0, "post_reset_scan");
            exp_p(1, 16'h0000, 0, "post_reset_scan");
            tick();
        end

        // Plain write then read
        we = 1; dst_addr = 3; dst = 16'hBEEF;
        tick();
        re0 = 1; p0_addr = 3;
        exp_p(0, 16'hBEEF, 0, "wr_then_rd");
        tick();

        // Same-cycle bypass on both ports
        we = 1; dst_addr = 5; dst = 16'h1234;
        re0 = 1; p0_addr = 5; re1 = 1; p1_addr = 5;
        exp_p(0, 16'h1234, 0, "bypass");
        exp_p(1, 16'h1234, 0, "bypass");
        tick();

        // Zero register ignores write, reserve and bypass
        we = 1; dst_addr = 0; dst = 16'hAAAA;
        rsv_en = 1; rsv_addr = 0;
        re0 = 1; p0_addr = 0; re1 = 1; p1_addr = 0;
        exp_p(0, 16'h0000, 0, "zero_bypass");
        exp_p(1, 16'h0000, 0, "zero_bypass");
        tick();
        re0 = 1; p0_addr = 0;
        exp_p(0, 16'h0000, 0, "zero_after");
        tick();

        // Scoreboard: reserve visible only on the following read
        rsv_en = 1; rsv_addr = 7;
        re1 = 1; p1_addr = 7;
        exp_p(1, 16'h0000, 0, "rsv_same_cycle");
        tick();
        re1 = 1; p1_addr = 7;
        exp_p(1, 16'h0000, 1, "rsv_pending");
        tick();
        we = 1; dst_addr = 7; dst = 16'h0042;
        re1 = 1; p1_addr = 7;
        exp_p(1, 16'h0042, 0, "wr_satisfies");
        tick();
        re1 = 1; p1_addr = 7;
        exp_p(1, 16'h0042, 0, "busy_cleared");
        tick();
        we = 1; dst_addr = 7; dst = 16'h0099;
        rsv_en = 1; rsv_addr = 7;
        re1 = 1; p1_addr = 7;
        exp_p(1, 16'h0099, 0, "collision_bypass");
        tick();
        re1 = 1; p1_addr = 7;
        exp_p(1, 16'h0099, 1, "collision_set_wins");
        tick();

        // Hold while a write hits the held address
        re0 = 1; p0_addr = 3;
        exp_p(0, 16'hBEEF, 0, "hold_setup");
        tick();
        we = 1; dst_addr = 3; dst = 16'h5555; p0_addr = 3;
        exp_p(0, 16'hBEEF, 0, "hold_p0");
        exp_p(1, 16'h0099, 1, "hold_p1");
        tick();
        re0 = 1; p0_addr = 3;
        exp_p(0, 16'h5555, 0, "hold_release");
        tick();

        // Distinct addresses on the two ports
        re0 = 1; p0_addr = 5; re1 = 1; p1_addr = 3;
        exp_p(0, 16'h1234, 0, "dual_rd");
        exp_p(1, 16'h5555, 0, "dual_rd");
        tick();

        // Mid-sequence reset discards reservation and data
        rsv_en = 1; rsv_addr = 2;
        tick();
        re0 = 1; p0_addr = 2;
        exp_p(0, 16'h0000, 1, "r2_reserved");
        tick();
        hlt = 1;
        tick();
        hlt = 0;
        rst = 1;
        exp_p(0, 16'h0000, 0, "mid_reset");
        exp_p(1, 16'h0000, 0, "mid_reset");
        tick();
        re0 = 1; p0_addr = 2; re1 = 1; p1_addr = 3;
        exp_p(0, 16'h0000, 0, "after_reset_r2");
        exp_p(1, 16'h0000, 0, "after_reset_r3");
        tick();
        re1 = 1; p1_addr = 7;
        exp_p(1, 16'h0000, 0, "after_reset_r7");
        tick();

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

endmodule
